// File: rtl/slot_dac_pkg.sv
// Shared constants, frame payload type and FSM state encoding for the slot DAC serializer.
package slot_dac_pkg;

    localparam int unsigned FRAME_BYTES = 6;
    localparam int unsigned SAMPLE_BITS = 24;
    localparam int unsigned SLOT_BCKS   = 32;
    localparam int unsigned FRAME_BITS  = FRAME_BYTES * 8;
    localparam int unsigned BIT_CNT_W   = $clog2(2 * SLOT_BCKS);
    localparam int unsigned SLOT_W      = $clog2(SLOT_BCKS);

    // One stereo frame, left sample in the upper half
    typedef struct packed {
        logic [SAMPLE_BITS-1:0] left;
        logic [SAMPLE_BITS-1:0] right;
    } frame_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } slot_dac_state_e;

endpackage

// File: rtl/slot_dac_serializer_if.sv
// Tracking-FIFO side and DAC-slot side signals of one serializer instance.
interface slot_dac_serializer_if #(
    parameter int unsigned ADDR_W = 11
);
    logic              enable;
    logic [ADDR_W-1:0] fifo_addr_in;
    logic [ADDR_W-1:0] fifo_addr_out;
    logic [7:0]        fifo_data;
    logic              fifo_read;
    logic              dac_bck;
    logic              dac_lrck;
    logic              dac_sdata;
    logic              underrun;
    logic              underrun_clear;

    modport master (
        output enable, fifo_addr_in, fifo_addr_out, fifo_data, underrun_clear,
        input  fifo_read, dac_bck, dac_lrck, dac_sdata, underrun
    );

    modport slave (
        input  enable, fifo_addr_in, fifo_addr_out, fifo_data, underrun_clear,
        output fifo_read, dac_bck, dac_lrck, dac_sdata, underrun
    );
endinterface

// File: rtl/slot_dac_frame_fetch.sv
// Pulls one whole stereo frame (6 bytes) from the tracking FIFO into a holding register.
module slot_dac_frame_fetch
    import slot_dac_pkg::*;
#(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_fetch_en,
    input  logic [ADDR_W-1:0] i_addr_in,
    input  logic [ADDR_W-1:0] i_addr_out,
    input  logic [7:0]        i_data,
    input  logic              i_take,
    output logic              o_read,
    output frame_t            o_hold,
    output logic              o_full
);

    localparam int unsigned CNT_W = $clog2(FRAME_BYTES + 1);

    logic [ADDR_W-1:0]     w_avail;
    logic                  w_start;
    logic                  r_busy;
    logic                  r_read;
    logic                  r_cap_vld;
    logic                  r_full;
    logic [CNT_W-1:0]      r_rd_cnt;
    logic [CNT_W-1:0]      r_cap_cnt;
    logic [FRAME_BITS-1:0] r_hold;

    // Modular pointer difference handles wrap for free
    assign w_avail = i_addr_in - i_addr_out;
    assign w_start = i_fetch_en && !r_full && !r_busy && (w_avail >= ADDR_W'(FRAME_BYTES));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_read    <= 1'b0;
            r_cap_vld <= 1'b0;
            r_full    <= 1'b0;
            r_rd_cnt  <= '0;
            r_cap_cnt <= '0;
            r_hold    <= '0;
        end else begin
            r_cap_vld <= r_read;

            if (w_start) begin
                r_busy   <= 1'b1;
                r_read   <= 1'b1;
                r_rd_cnt <= CNT_W'(1);
            end else if (r_busy && (r_rd_cnt != CNT_W'(FRAME_BYTES))) begin
                r_read   <= 1'b1;
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end else begin
                r_read <= 1'b0;
            end

            if (i_take) begin
                r_full <= 1'b0;
            end

            // Byte arrives the cycle after its pop; first byte ends up in the MSBs
            if (r_cap_vld) begin
                r_hold <= {r_hold[FRAME_BITS-9:0], i_data};
                if (r_cap_cnt == CNT_W'(FRAME_BYTES - 1)) begin
                    r_full    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_cap_cnt <= '0;
                end else begin
                    r_cap_cnt <= r_cap_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_read = r_read;
    assign o_hold = r_hold;
    assign o_full = r_full;

endmodule

// File: rtl/slot_dac_serializer.sv
// Left-justified 24-bit stereo serializer for one DAC slot, fed from its tracking FIFO.
// Define SLOT_DAC_SER_UNDERRUN_REPEAT_EN to re-send the previous frame on underrun.
module slot_dac_serializer
    import slot_dac_pkg::*;
#(
    parameter int unsigned BCK_DIV = 8,
    parameter int unsigned ADDR_W  = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    slot_dac_serializer_if.slave bus
);

    localparam int unsigned DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

    slot_dac_state_e       r_state;
    slot_dac_state_e       w_state_nxt;
    logic [DIV_W-1:0]      r_div;
    logic                  r_bck;
    logic                  r_lrck;
    logic                  r_sdata;
    logic                  r_underrun;
    logic [BIT_CNT_W-1:0]  r_bit;
    logic [BIT_CNT_W-1:0]  w_bit_nxt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] w_frame;
    logic [FRAME_BITS-1:0] w_fill;
    logic                  w_fall;
    logic                  w_boundary;
    logic                  w_load;
    logic                  w_take;
    logic                  w_urun;
    logic                  w_full;
    logic                  w_read;
    frame_t                w_hold;

    slot_dac_frame_fetch #(
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .clk        (clk),
        .reset      (reset),
        .i_fetch_en (bus.enable),
        .i_addr_in  (bus.fifo_addr_in),
        .i_addr_out (bus.fifo_addr_out),
        .i_data     (bus.fifo_data),
        .i_take     (w_take),
        .o_read     (w_read),
        .o_hold     (w_hold),
        .o_full     (w_full)
    );

    assign w_fall     = (r_state == RUN) && r_bck && (r_div == DIV_W'(BCK_DIV - 1));
    assign w_boundary = w_fall && (r_bit == BIT_CNT_W'(2 * SLOT_BCKS - 1));
    assign w_bit_nxt  = r_bit + BIT_CNT_W'(1);

`ifdef SLOT_DAC_SER_UNDERRUN_REPEAT_EN
    logic [FRAME_BITS-1:0] r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= '0;
        end else if (w_load) begin
            r_last <= w_frame;
        end
    end

    assign w_fill = r_last;
`else
    assign w_fill = '0;
`endif

    assign w_frame = w_full ? w_hold : w_fill;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus frame load / holding release / underrun decisions
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_take      = 1'b0;
        w_urun      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.enable) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (!bus.enable) begin
                    w_state_nxt = IDLE;
                end else if (w_full) begin
                    w_load      = 1'b1;
                    w_take      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_boundary) begin
                    if (!bus.enable) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_load = 1'b1;
                        w_take = w_full;
                        w_urun = !w_full;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div      <= '0;
            r_bck      <= 1'b0;
            r_lrck     <= 1'b0;
            r_sdata    <= 1'b0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_underrun <= 1'b0;
        end else begin
            // BCK divider restarts on entry to RUN so the first rise lands BCK_DIV cycles later
            if ((r_state == RUN) && (w_state_nxt == RUN)) begin
                if (r_div == DIV_W'(BCK_DIV - 1)) begin
                    r_div <= '0;
                    r_bck <= ~r_bck;
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
            end else begin
                r_div <= '0;
                r_bck <= 1'b0;
            end

            if (w_state_nxt != RUN) begin
                r_lrck  <= 1'b0;
                r_sdata <= 1'b0;
                r_bit   <= '0;
            end else if (w_load) begin
                r_shift <= {w_frame[FRAME_BITS-2:0], 1'b0};
                r_sdata <= w_frame[FRAME_BITS-1];
                r_lrck  <= 1'b0;
                r_bit   <= '0;
            end else if (w_fall) begin
                r_bit  <= w_bit_nxt;
                r_lrck <= w_bit_nxt[BIT_CNT_W-1];
                if (w_bit_nxt[SLOT_W-1:0] < SLOT_W'(SAMPLE_BITS)) begin
                    r_sdata <= r_shift[FRAME_BITS-1];
                    r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                end else begin
                    r_sdata <= 1'b0;
                end
            end

            if (w_urun) begin
                r_underrun <= 1'b1;
            end else if (bus.underrun_clear) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign bus.fifo_read = w_read;
    assign bus.dac_bck   = r_bck;
    assign bus.dac_lrck  = r_lrck;
    assign bus.dac_sdata = r_sdata;
    assign bus.underrun  = r_underrun;

endmodule

// File: tb/tb_slot_dac_serializer.sv
// Directed bench for slot_dac_serializer: FIFO model, serial frame capture, immediate assertions.
module tb_slot_dac_serializer;
    import slot_dac_pkg::*;

    localparam int unsigned BCK_DIV = 4;
    localparam int unsigned ADDR_W  = 11;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_load;
    logic [ADDR_W-1:0] rd_load_val;
    int                rd_cnt;

    slot_dac_serializer_if #(.ADDR_W(ADDR_W)) bus ();

    slot_dac_serializer #(
        .BCK_DIV (BCK_DIV),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.fifo_addr_out = rd_ptr;

    // Tracking FIFO read side: data valid the cycle after the pop
    always @(posedge clk) begin
        if (rd_load) begin
            rd_ptr <= rd_load_val;
            rd_cnt <= 0;
        end else if (bus.fifo_read) begin
            bus.fifo_data <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1'b1;
            rd_cnt        <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Collect 64 bits sampled on BCK rising edges; optionally drop enable after drop_at bits
    task automatic get_frame(input int drop_at, output logic [63:0] d, output logic [63:0] l,
                             output logic ok);
        int   n;
        int   guard;
        logic prev;
        n     = 0;
        guard = 0;
        d     = '0;
        l     = '0;
        prev  = bus.dac_bck;
        while ((n < 64) && (guard < 200 * int'(BCK_DIV))) begin
            @(negedge clk);
            guard++;
            if (bus.dac_bck && !prev) begin
                d[63-n] = bus.dac_sdata;
                l[63-n] = bus.dac_lrck;
                n++;
                if (n == drop_at) bus.enable = 1'b0;
            end
            prev = bus.dac_bck;
        end
        ok = (n == 64);
    endtask

    localparam logic [63:0] LR_EXP = 64'h00000000_FFFFFFFF;

    initial begin
        logic [63:0] d;
        logic [63:0] l;
        logic        ok;
        logic        quiet;
        logic [63:0] exp2;

        checks             = 0;
        errors             = 0;
        reset              = 1'b1;
        bus.enable         = 1'b0;
        bus.underrun_clear = 1'b0;
        bus.fifo_addr_in   = ADDR_W'(0);
        rd_load            = 1'b1;
        rd_load_val        = '0;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        rd_load = 1'b0;
        @(negedge clk);

        chk("rst_bck",   {63'd0, bus.dac_bck},   64'd0);
        chk("rst_lrck",  {63'd0, bus.dac_lrck},  64'd0);
        chk("rst_sdata", {63'd0, bus.dac_sdata}, 64'd0);
        chk("rst_read",  {63'd0, bus.fifo_read}, 64'd0);
        chk("rst_urun",  {63'd0, bus.underrun},  64'd0);

        // Disabled slot with plenty of data: nothing moves
        bus.fifo_addr_in = ADDR_W'(100);
        quiet = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.fifo_read || bus.dac_bck || bus.dac_lrck || bus.dac_sdata || bus.underrun)
                quiet = 1'b0;
        end
        chk("idle_quiet", {63'd0, quiet}, 64'd1);
        chk("idle_reads", 64'(rd_cnt), 64'd0);

        // One frame of data, then starve
        mem[0] = 8'hAB; mem[1] = 8'hCD; mem[2] = 8'hEF;
        mem[3] = 8'h12; mem[4] = 8'h34; mem[5] = 8'h56;
        bus.fifo_addr_in = ADDR_W'(6);
        bus.enable = 1'b1;
        get_frame(-1, d, l, ok);
        chk("f1_done",  {63'd0, ok}, 64'd1);
        chk("f1_data",  d, 64'hABCDEF00_12345600);
        chk("f1_lrck",  l, LR_EXP);
        chk("f1_reads", 64'(rd_cnt), 64'd6);
        chk("f1_urun",  {63'd0, bus.underrun}, 64'd0);

        get_frame(-1, d, l, ok);
`ifdef SLOT_DAC_SER_UNDERRUN_REPEAT_EN
        exp2 = 64'hABCDEF00_12345600;
`else
        exp2 = 64'd0;
`endif
        chk("f2_done", {63'd0, ok}, 64'd1);
        chk("f2_data", d, exp2);
        chk("f2_lrck", l, LR_EXP);
        chk("f2_urun", {63'd0, bus.underrun}, 64'd1);
        bus.underrun_clear = 1'b1;
        @(negedge clk);
        bus.underrun_clear = 1'b0;
        chk("urun_clr", {63'd0, bus.underrun}, 64'd0);

        // One-cycle reset in the middle of a frame
        repeat (100) @(negedge clk);
        reset      = 1'b1;
        bus.enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_bck",   {63'd0, bus.dac_bck},   64'd0);
        chk("mid_rst_lrck",  {63'd0, bus.dac_lrck},  64'd0);
        chk("mid_rst_sdata", {63'd0, bus.dac_sdata}, 64'd0);
        chk("mid_rst_read",  {63'd0, bus.fifo_read}, 64'd0);
        chk("mid_rst_urun",  {63'd0, bus.underrun},  64'd0);

        // Fresh data straddling the pointer wrap, followed by a second frame
        rd_load     = 1'b1;
        rd_load_val = ADDR_W'(2045);
        @(negedge clk);
        rd_load = 1'b0;
        mem[2045] = 8'h9A; mem[2046] = 8'hBC; mem[2047] = 8'hDE;
        mem[0]    = 8'hF0; mem[1]    = 8'h0F; mem[2]    = 8'h5A;
        mem[3]    = 8'h01; mem[4]    = 8'h23; mem[5]    = 8'h45;
        mem[6]    = 8'h67; mem[7]    = 8'h89; mem[8]    = 8'hFE;
        bus.fifo_addr_in = ADDR_W'(9);
        bus.enable = 1'b1;
        get_frame(-1, d, l, ok);
        chk("wrap_done", {63'd0, ok}, 64'd1);
        chk("wrap_data", d, 64'h9ABCDE00_F00F5A00);
        chk("wrap_lrck", l, LR_EXP);

        // Enable dropped partway through the right word
        get_frame(40, d, l, ok);
        chk("stop_done", {63'd0, ok}, 64'd1);
        chk("stop_data", d, 64'h01234500_6789FE00);
        chk("stop_lrck", l, LR_EXP);
        chk("stop_urun", {63'd0, bus.underrun}, 64'd0);
        repeat (10) @(negedge clk);
        quiet = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.dac_bck || bus.dac_lrck || bus.dac_sdata || bus.fifo_read) quiet = 1'b0;
        end
        chk("stop_quiet", {63'd0, quiet}, 64'd1);
        chk("stop_state", {62'd0, dut.r_state}, {62'd0, IDLE});
        chk("stop_reads", 64'(rd_cnt), 64'd12);
        chk("stop_rdptr", {53'd0, rd_ptr}, 64'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
